// File: rtl/lmc_core.sv
// lmc_core: LMC accumulator processor with push-button program/data loading.
// Instruction RAM + data RAM, 16-opcode accumulator ISA, IN handshake, OUT strobe.
module lmc_core #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 4
) (
    input  logic                  timer555,
    input  logic                  reset_count_n,
    input  logic                  load_mode,
    input  logic                  load_sel,
    input  logic                  wr_button,
    input  logic [DATA_WIDTH+3:0] data_in,
    input  logic                  run,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH+3:0] instr,
    output logic [DATA_WIDTH-1:0] acc,
    output logic                  zero,
    output logic                  carry,
    output logic [ADDR_WIDTH-1:0] load_ptr,
    output logic                  halted
);

    localparam int IW    = DATA_WIDTH + 4;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_ADI = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_JC  = 4'h9;
    localparam logic [3:0] OP_IN  = 4'hA;
    localparam logic [3:0] OP_OUT = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [IW-1:0]         instr_q, instr_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  zero_q, zero_d;
    logic                  carry_q, carry_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [ADDR_WIDTH-1:0] load_ptr_q, load_ptr_d;
    logic                  btn_q;

    logic [IW-1:0]         imem [DEPTH];
    logic [DATA_WIDTH-1:0] dmem [DEPTH];

    logic                  imem_we;
    logic                  dmem_we;
    logic [ADDR_WIDTH-1:0] dmem_waddr;
    logic [DATA_WIDTH-1:0] dmem_wdata;

    logic [3:0]            opcode;
    logic [DATA_WIDTH-1:0] operand;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] dmem_rd;
    logic [DATA_WIDTH:0]   add_mem;
    logic [DATA_WIDTH:0]   sub_mem;
    logic [DATA_WIDTH:0]   add_imm;
    logic                  btn_rise;

    assign opcode   = instr_q[IW-1 -: 4];
    assign operand  = instr_q[DATA_WIDTH-1:0];
    assign addr_a   = operand[ADDR_WIDTH-1:0];
    assign dmem_rd  = dmem[addr_a];
    assign add_mem  = {1'b0, acc_q} + {1'b0, dmem_rd};
    assign sub_mem  = {1'b0, acc_q} - {1'b0, dmem_rd};
    assign add_imm  = {1'b0, acc_q} + {1'b0, operand};
    assign btn_rise = wr_button & ~btn_q;

    // Next-state: load_mode preempts everything, then the per-state rules.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        acc_d       = acc_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        load_ptr_d  = load_ptr_q;
        imem_we     = 1'b0;
        dmem_we     = 1'b0;
        dmem_waddr  = addr_a;
        dmem_wdata  = acc_q;
        if (load_mode) begin
            state_d = S_LOAD;
            if (state_q != S_LOAD) begin
                load_ptr_d = '0;
            end else if (btn_rise) begin
                imem_we    = ~load_sel;
                dmem_we    = load_sel;
                dmem_waddr = load_ptr_q;
                dmem_wdata = data_in[DATA_WIDTH-1:0];
                load_ptr_d = load_ptr_q + PC_ONE;
            end
        end else begin
            unique case (state_q)
                S_IDLE, S_HALT: begin
                    if (run) begin
                        state_d = S_FETCH;
                        pc_d    = '0;
                        acc_d   = '0;
                        zero_d  = 1'b0;
                        carry_d = 1'b0;
                    end
                end
                S_LOAD: state_d = S_IDLE;
                S_FETCH: begin
                    instr_d = imem[pc_q];
                    state_d = S_EXEC;
                end
                S_EXEC: begin
                    state_d = S_FETCH;
                    pc_d    = pc_q + PC_ONE;
                    unique case (opcode)
                        OP_NOP: ;
                        OP_LDI: begin
                            acc_d  = operand;
                            zero_d = (operand == '0);
                        end
                        OP_LDA: begin
                            acc_d  = dmem_rd;
                            zero_d = (dmem_rd == '0);
                        end
                        OP_STA: dmem_we = 1'b1;
                        OP_ADD: begin
                            {carry_d, acc_d} = add_mem;
                            zero_d = (add_mem[DATA_WIDTH-1:0] == '0);
                        end
                        OP_SUB: begin
                            {carry_d, acc_d} = sub_mem;
                            zero_d = (sub_mem[DATA_WIDTH-1:0] == '0);
                        end
                        OP_ADI: begin
                            {carry_d, acc_d} = add_imm;
                            zero_d = (add_imm[DATA_WIDTH-1:0] == '0);
                        end
                        OP_JMP: pc_d = addr_a;
                        OP_JZ:  if (zero_q) pc_d = addr_a;
                        OP_JC:  if (carry_q) pc_d = addr_a;
                        OP_IN: begin
                            if (in_valid) begin
                                acc_d  = in_data;
                                zero_d = (in_data == '0);
                            end else begin
                                state_d = S_EXEC;
                                pc_d    = pc_q;
                            end
                        end
                        OP_OUT: begin
                            out_data_d  = acc_q;
                            out_valid_d = 1'b1;
                        end
                        OP_HLT: begin
                            state_d = S_HALT;
                            pc_d    = pc_q;
                        end
                        default: ;
                    endcase
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Architectural state and button edge detector.
    always_ff @(posedge timer555 or negedge reset_count_n) begin
        if (!reset_count_n) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            instr_q     <= '0;
            acc_q       <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            load_ptr_q  <= '0;
            btn_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            acc_q       <= acc_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            load_ptr_q  <= load_ptr_d;
            btn_q       <= wr_button;
        end
    end

    // RAM writes; contents deliberately survive reset.
    always_ff @(posedge timer555) begin
        if (imem_we) imem[load_ptr_q] <= data_in;
        if (dmem_we) dmem[dmem_waddr] <= dmem_wdata;
    end

    assign in_ready  = (state_q == S_EXEC) && (opcode == OP_IN);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign acc       = acc_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign load_ptr  = load_ptr_q;
    assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_lmc_core.sv
// tb_lmc_core: directed vectors for lmc_core.
// Loads small programs, runs them cycle by cycle, checks hand-computed results.
module tb_lmc_core;

    logic       clk;
    logic       rst_n;
    logic       load_mode;
    logic       load_sel;
    logic       wr_button;
    logic [7:0] data_in;
    logic       run;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out_data;
    logic       out_valid;
    logic [2:0] pc;
    logic [7:0] instr;
    logic [3:0] acc;
    logic       zero;
    logic       carry;
    logic [2:0] load_ptr;
    logic       halted;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] prog[$];
    int path[5] = '{0, 1, 2, 5, 6};
    int n_out;

    lmc_core #(
        .ADDR_WIDTH(3),
        .DATA_WIDTH(4)
    ) dut (
        .timer555     (clk),
        .reset_count_n(rst_n),
        .load_mode    (load_mode),
        .load_sel     (load_sel),
        .wr_button    (wr_button),
        .data_in      (data_in),
        .run          (run),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .pc           (pc),
        .instr        (instr),
        .acc          (acc),
        .zero         (zero),
        .carry        (carry),
        .load_ptr     (load_ptr),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] w);
        data_in   = w;
        wr_button = 1'b1;
        tick(2);
        wr_button = 1'b0;
        tick(1);
    endtask

    task automatic load_prog(input logic sel);
        load_mode = 1'b1;
        load_sel  = sel;
        tick(1);
        foreach (prog[i]) press(prog[i]);
        load_mode = 1'b0;
        tick(1);
    endtask

    task automatic start();
        run = 1'b1;
        tick(1);
        run = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        load_mode = 1'b0;
        load_sel  = 1'b0;
        wr_button = 1'b0;
        data_in   = '0;
        run       = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        tick(2);
        check_eq("rst_pc", pc, 0);
        check_eq("rst_acc", acc, 0);
        check_eq("rst_instr", instr, 0);
        check_eq("rst_flags", {zero, carry, halted, in_ready, out_valid}, 0);
        check_eq("rst_ptr", load_ptr, 0);
        rst_n = 1'b1;
        tick(1);

        // LDI 5; ADI 3; OUT; HLT
        prog = '{8'h15, 8'h63, 8'hB0, 8'hF0};
        load_prog(1'b0);
        check_eq("t1_ptr", load_ptr, 4);
        start();
        n_out = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            if (out_valid) n_out++;
            if (i == 1) check_eq("t1_fetch", instr, 8'h15);
            if (i == 2) check_eq("t1_ldi", acc, 5);
            if (i == 7) check_eq("t1_halt_early", halted, 0);
        end
        check_eq("t1_nout", n_out, 1);
        check_eq("t1_out", out_data, 8);
        check_eq("t1_acc", acc, 8);
        check_eq("t1_zc", {zero, carry}, 2'b00);
        check_eq("t1_halted", halted, 1);

        // LDI 15; ADI 1; JZ 5; HLT; HLT; OUT; HLT
        prog = '{8'h1F, 8'h61, 8'h85, 8'hF0, 8'hF0, 8'hB0, 8'hF0};
        load_prog(1'b0);
        start();
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (i % 2 == 1) check_eq("t2_pc", pc, path[i/2]);
            if (i == 4) begin
                check_eq("t2_acc", acc, 0);
                check_eq("t2_zc", {zero, carry}, 2'b11);
            end
            if (i == 8) check_eq("t2_ovalid", out_valid, 1);
        end
        check_eq("t2_out", out_data, 0);
        check_eq("t2_halted", halted, 1);

        // dmem: [0]=7 (upper bits of 0x57 dropped), [1]=0, [2]=0xA
        prog = '{8'h57, 8'h00, 8'h0A};
        load_prog(1'b1);
        // LDI 3; SUB [0]; STA [1]; LDA [2]; OUT; LDA [1]; HLT
        prog = '{8'h13, 8'h50, 8'h31, 8'h22, 8'hB0, 8'h21, 8'hF0};
        load_prog(1'b0);
        start();
        for (int i = 1; i <= 14; i++) begin
            tick(1);
            if (i == 4) begin
                check_eq("t3_sub", acc, 4'hC);
                check_eq("t3_borrow", carry, 1);
            end
        end
        check_eq("t3_lda2", out_data, 4'hA);
        check_eq("t3_sta", acc, 4'hC);
        check_eq("t3_zc", {zero, carry}, 2'b01);
        check_eq("t3_halted", halted, 1);

        // IN; OUT; HLT
        prog = '{8'hA0, 8'hB0, 8'hF0};
        load_prog(1'b0);
        start();
        tick(1);
        for (int i = 0; i < 5; i++) begin
            check_eq("t4_ready", in_ready, 1);
            check_eq("t4_pc", pc, 0);
            tick(1);
        end
        in_data  = 4'h9;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        check_eq("t4_acc", acc, 9);
        check_eq("t4_pc1", pc, 1);
        check_eq("t4_ready0", in_ready, 0);
        tick(4);
        check_eq("t4_out", out_data, 9);
        check_eq("t4_halted", halted, 1);

        // reset in the middle of the first program
        prog = '{8'h15, 8'h63, 8'hB0, 8'hF0};
        load_prog(1'b0);
        start();
        tick(2);
        check_eq("t5_pre", acc, 5);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_rst_acc", acc, 0);
        check_eq("t5_rst_pc", pc, 0);
        check_eq("t5_rst_instr", instr, 0);
        check_eq("t5_rst_misc", {out_data, load_ptr, zero, carry, halted}, 0);
        rst_n = 1'b1;
        tick(1);
        start();
        tick(8);
        check_eq("t5_out", out_data, 8);
        check_eq("t5_acc", acc, 8);
        check_eq("t5_halted", halted, 1);

        // nine presses wrap the pointer; ninth word lands in imem[0]
        prog = '{8'h00, 8'h70, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1B};
        load_prog(1'b0);
        check_eq("t6_ptr_wrap", load_ptr, 1);
        start();
        tick(1);
        check_eq("t6_imem0", instr, 8'h1B);
        tick(1);
        check_eq("t6_acc", acc, 4'hB);
        tick(1);
        load_mode = 1'b1;
        tick(1);
        check_eq("t6_abort_ptr", load_ptr, 0);
        check_eq("t6_abort_pc", pc, 1);
        press(8'h00);
        check_eq("t6_load_wr", load_ptr, 1);
        load_mode = 1'b0;
        tick(1);

        // run and load_mode together: load wins
        run       = 1'b1;
        load_mode = 1'b1;
        tick(1);
        run       = 1'b0;
        check_eq("t7_ptr", load_ptr, 0);
        check_eq("t7_pc", pc, 1);
        load_mode = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
